// File: rtl/irq_request_latch_pkg.sv
// pic_pkg: shared constants and the lowest-index priority helper for irq_request_latch.
package pic_pkg;

    localparam int   NUM_IRQ_DEF = 8;
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_LEVEL  = 1'b1;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } prio_t;

    // Scans from the top so the last hit, and therefore the winner, is the lowest index.
    function automatic prio_t prio_lowest_idx(input logic [31:0] vec);
        prio_t r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_request_latch_if.sv
// irq_request_latch_if: request/mask/ack bus between the PIC control logic and irq_request_latch.
interface irq_request_latch_if #(
    parameter int NUM_IRQ = pic_pkg::NUM_IRQ_DEF,
    parameter int IDX_W   = $clog2(NUM_IRQ)
);
    logic [NUM_IRQ-1:0] ir_in;
    logic               level_or_edge_flag;
    logic [NUM_IRQ-1:0] mask;
    logic               init_clr;
    logic               ack_valid;
    logic [IDX_W-1:0]   ack_idx;
    logic [NUM_IRQ-1:0] irr;
    logic               req_valid;
    logic [IDX_W-1:0]   req_idx;

    modport master (
        output ir_in, level_or_edge_flag, mask, init_clr, ack_valid, ack_idx,
        input  irr, req_valid, req_idx
    );

    modport slave (
        input  ir_in, level_or_edge_flag, mask, init_clr, ack_valid, ack_idx,
        output irr, req_valid, req_idx
    );
endinterface

// File: rtl/irq_request_latch_channel.sv
// irq_channel: one request bit with edge history; optional input synchronizer via IRQ_INPUT_SYNC_EN.
module irq_channel
    import pic_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_init_clr,
    input  logic i_level,
    input  logic i_ir,
    input  logic i_ack,
    output logic o_irr
);
    logic w_ir;
    logic w_next;
    logic r_prev;
    logic r_irr;

`ifdef IRQ_INPUT_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        r_sync <= !rst_n ? 2'b00 : {r_sync[0], i_ir};
    end

    assign w_ir = r_sync[1];
`else
    assign w_ir = i_ir;
`endif

    // A low line drops the request in both modes; ack beats any set.
    assign w_next = (i_ack || !w_ir) ? 1'b0 :
                    (i_level == MODE_LEVEL) ? 1'b1 : (r_irr || !r_prev);

    always_ff @(posedge clk) begin
        if (!rst_n || i_init_clr) begin
            r_irr  <= 1'b0;
            r_prev <= 1'b1;
        end else begin
            r_irr  <= w_next;
            r_prev <= w_ir;
        end
    end

    assign o_irr = r_irr;
endmodule

// File: rtl/irq_request_latch.sv
// irq_request_latch: PIC request register with masking and registered lowest-index priority.
// Optional IRQ_INPUT_SYNC_EN adds a 2-flop synchronizer on every request line.
module irq_request_latch
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input logic                clk,
    input logic                rst_n,
    irq_request_latch_if.slave bus
);
    logic [NUM_IRQ-1:0] w_irr;
    logic [NUM_IRQ-1:0] w_ack;
    logic [NUM_IRQ-1:0] w_req;
    prio_t              w_prio;
    logic               r_req_valid;
    logic [IDX_W-1:0]   r_req_idx;

    // Out-of-range ack_idx matches no channel and is therefore ignored.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
        assign w_ack[i] = bus.ack_valid && (bus.ack_idx == IDX_W'(i));
        irq_channel u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_init_clr (bus.init_clr),
            .i_level    (bus.level_or_edge_flag),
            .i_ir       (bus.ir_in[i]),
            .i_ack      (w_ack[i]),
            .o_irr      (w_irr[i])
        );
    end

    assign w_req  = w_irr & ~bus.mask;
    assign w_prio = prio_lowest_idx(32'(w_req));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_valid <= 1'b0;
            r_req_idx   <= '0;
        end else begin
            r_req_valid <= w_prio.valid;
            r_req_idx   <= IDX_W'(w_prio.idx);
        end
    end

    assign bus.irr       = w_irr;
    assign bus.req_valid = r_req_valid;
    assign bus.req_idx   = r_req_idx;
endmodule

// File: tb/tb_irq_request_latch.sv
// tb_irq_request_latch: directed scoreboard bench for irq_request_latch (8 channels).
module tb_irq_request_latch;
    import pic_pkg::*;

`ifdef IRQ_INPUT_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    typedef struct {
        string      tag;
        int         due;
        bit         is_req;
        logic [7:0] irr;
        logic       rv;
        logic [2:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    irq_request_latch_if #(.NUM_IRQ(8)) bus ();

    irq_request_latch #(.NUM_IRQ(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic exp_irr(input string t, input int k, input logic [7:0] v);
        exp_t e;
        e.tag = t; e.due = cyc + k; e.is_req = 1'b0; e.irr = v; e.rv = 1'b0; e.idx = 3'd0;
        sb.push_back(e);
    endtask

    task automatic exp_req(input string t, input int k, input logic rv, input logic [2:0] idx);
        exp_t e;
        e.tag = t; e.due = cyc + k; e.is_req = 1'b1; e.irr = 8'h00; e.rv = rv; e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t keep[$];
        @(posedge clk);
        #1;
        cyc++;
        foreach (sb[j]) begin
            if (sb[j].due != cyc) begin
                keep.push_back(sb[j]);
            end else if (sb[j].is_req) begin
                checks++;
                assert ({bus.req_valid, bus.req_idx} === {sb[j].rv, sb[j].idx}) else begin
                    errors++;
                    $error("FAIL %s: req_valid/req_idx got %b/%0d expected %b/%0d",
                           sb[j].tag, bus.req_valid, bus.req_idx, sb[j].rv, sb[j].idx);
                end
            end else begin
                checks++;
                assert (bus.irr === sb[j].irr) else begin
                    errors++;
                    $error("FAIL %s: irr got %h expected %h", sb[j].tag, bus.irr, sb[j].irr);
                end
            end
        end
        sb = keep;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ir_in = 8'h04;
        bus.level_or_edge_flag = MODE_EDGE;
        bus.mask = 8'h00;
        bus.init_clr = 1'b0;
        bus.ack_valid = 1'b0;
        bus.ack_idx = 3'd0;
        tick();
        exp_irr("reset_irr", 1, 8'h00);
        exp_req("reset_req", 1, 1'b0, 3'd0);
        tick();
        rst_n = 1'b1;
`ifndef IRQ_INPUT_SYNC_EN
        exp_irr("held_thru_reset_1", 1, 8'h00);
        exp_irr("held_thru_reset_3", 3, 8'h00);
`endif
        ticks(3);
        bus.ir_in = 8'h00;
        ticks(L + 2);
        bus.ir_in = 8'h04;
        exp_irr("edge_ir2", 1 + L, 8'h04);
        exp_req("edge_ir2_req", 2 + L, 1'b1, 3'd2);
        ticks(2 + L);
        bus.ack_valid = 1'b1;
        bus.ack_idx = 3'd2;
        exp_irr("ack2", 1, 8'h00);
        exp_req("ack2_req", 2, 1'b0, 3'd0);
        tick();
        bus.ack_valid = 1'b0;
        exp_irr("ack2_hold", 2, 8'h00);
        ticks(3);
        bus.ir_in = 8'h00;
        ticks(L + 2);

        bus.ir_in = 8'h08;
        exp_irr("edge_ir3", 1 + L, 8'h08);
        exp_req("edge_ir3_req", 2 + L, 1'b1, 3'd3);
        ticks(2 + L);
        bus.ack_valid = 1'b1;
        bus.ack_idx = 3'd3;
        exp_irr("ack3", 1, 8'h00);
        exp_req("ack3_req", 2, 1'b0, 3'd0);
        tick();
        bus.ack_valid = 1'b0;
        exp_irr("ack3_hold", 2, 8'h00);
        ticks(3);
        bus.ir_in = 8'h00;
        ticks(L + 2);

        bus.level_or_edge_flag = MODE_LEVEL;
        bus.ir_in = 8'h20;
        exp_irr("lvl5", 1 + L, 8'h20);
        ticks(1 + L);
        bus.ack_valid = 1'b1;
        bus.ack_idx = 3'd5;
        exp_irr("lvl5_ack", 1, 8'h00);
        exp_irr("lvl5_reassert", 2, 8'h20);
        tick();
        bus.ack_valid = 1'b0;
        tick();
        bus.ir_in = 8'h00;
        exp_irr("lvl5_drop", 1 + L, 8'h00);
        ticks(2 + L);
        bus.level_or_edge_flag = MODE_EDGE;

        bus.mask = 8'h01;
        bus.ir_in = 8'h81;
        exp_irr("mask_irr", 1 + L, 8'h81);
        exp_req("mask_req", 2 + L, 1'b1, 3'd7);
        ticks(2 + L);
        bus.mask = 8'h00;
        exp_req("unmask_req", 1, 1'b1, 3'd0);
        tick();
        bus.mask = 8'hFF;
        exp_req("allmask_req", 1, 1'b0, 3'd0);
        exp_irr("allmask_irr", 1, 8'h81);
        tick();
        bus.mask = 8'h00;

        bus.ir_in = 8'hFF;
        exp_irr("all_irr", 1 + L, 8'hFF);
        ticks(1 + L);
        bus.init_clr = 1'b1;
        bus.ack_valid = 1'b1;
        bus.ack_idx = 3'd0;
        exp_irr("init_clr", 1, 8'h00);
        exp_req("init_clr_req_prev", 1, 1'b1, 3'd0);
        exp_req("init_clr_req", 2, 1'b0, 3'd0);
        tick();
        bus.init_clr = 1'b0;
        bus.ack_valid = 1'b0;
        exp_irr("init_no_relatch", 2, 8'h00);
        ticks(3);

        bus.ir_in = 8'h00;
        ticks(L + 2);
        bus.ir_in = 8'h10;
        exp_irr("pre_rst", 1 + L, 8'h10);
        exp_req("pre_rst_req", 2 + L, 1'b1, 3'd4);
        ticks(2 + L);
        rst_n = 1'b0;
        exp_irr("mid_rst", 1, 8'h00);
        exp_req("mid_rst_req", 1, 1'b0, 3'd0);
        tick();
        rst_n = 1'b1;
`ifndef IRQ_INPUT_SYNC_EN
        exp_irr("post_rst_no_edge", 2, 8'h00);
`endif
        ticks(3);
        bus.ir_in = 8'h00;
        ticks(L + 2);

        bus.ir_in = 8'h01;
        exp_irr("pulse_set", 1 + L, 8'h01);
        exp_req("pulse_req", 2 + L, 1'b1, 3'd0);
        ticks(4);
        bus.ir_in = 8'h00;
        exp_irr("pulse_clr", 1 + L, 8'h00);
        ticks(2 + L);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
